// File: rtl/oscaler_ctrl.sv
// Output-scaler sequencer: issues psum vectors with per-group scales into a fixed-latency
// scaler and collects results into a credit-protected output FIFO.
module oscaler_ctrl #(
  parameter int NUM_ELEMENTS   = 4,
  parameter int ELEMENT_WIDTH  = 20,
  parameter int OUTPUT_WIDTH   = 8,
  parameter int SCALE_WIDTH    = 16,
  parameter int SHIFT_WIDTH    = 4,
  parameter int NUM_GROUPS_MAX = 16,
  parameter int SCALER_LATENCY = 2,
  parameter int FIFO_DEPTH     = 4,
  localparam int AW = $clog2(NUM_GROUPS_MAX),
  localparam int DW = NUM_ELEMENTS*ELEMENT_WIDTH,
  localparam int SW = NUM_ELEMENTS*SCALE_WIDTH,
  localparam int OW = NUM_ELEMENTS*OUTPUT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [AW-1:0]          cfg_addr,
  input  logic [SW-1:0]          cfg_wdata,
  input  logic                   cfg_shift_we,
  input  logic [SHIFT_WIDTH-1:0] cfg_shift,
  input  logic                   start,
  input  logic [15:0]            total_vectors,
  input  logic [AW:0]            num_groups,
  output logic                   busy,
  output logic                   done,
  input  logic                   psum_valid_i,
  output logic                   psum_ready_o,
  input  logic [DW-1:0]          psum_data_i,
  output logic [DW-1:0]          sc_wx_o,
  output logic [SW-1:0]          sc_scale_o,
  output logic [SHIFT_WIDTH-1:0] sc_shift_o,
  input  logic [OW-1:0]          sc_y_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [OW-1:0]          out_data_o,
  output logic [AW-1:0]          out_group_o
);
  localparam int L  = SCALER_LATENCY;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + L + 2) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [15:0]            issued_q, issued_d, total_q, total_d;
  logic [AW:0]            ngrp_q, ngrp_d;
  logic [AW-1:0]          grp_q, grp_d;
  logic [SW-1:0]          tbl_q [NUM_GROUPS_MAX];
  logic [SW-1:0]          tbl_d [NUM_GROUPS_MAX];
  logic [SHIFT_WIDTH-1:0] shift_q, shift_d;
  logic [DW-1:0]          wx_q, wx_d;
  logic [SW-1:0]          scale_q, scale_d;
  logic [SHIFT_WIDTH-1:0] scsh_q, scsh_d;
  logic [L:0]             vld_q, vld_d;
  logic [AW-1:0]          tag_q [L+1];
  logic [AW-1:0]          tag_d [L+1];
  logic [OW-1:0]          fdat_q [FIFO_DEPTH];
  logic [OW-1:0]          fdat_d [FIFO_DEPTH];
  logic [AW-1:0]          ftag_q [FIFO_DEPTH];
  logic [AW-1:0]          ftag_d [FIFO_DEPTH];
  logic [PW-1:0]          wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]          cnt_q, cnt_d, inflight;
  logic                   fire, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i <= L; i++) inflight = inflight + CW'(vld_q[i]);
  end

  // Credit covers both queued and in-flight results, so a push never finds the FIFO full.
  assign psum_ready_o = (state_q == S_RUN) && (issued_q < total_q) &&
                        ((cnt_q + inflight) < CW'(FIFO_DEPTH));
  assign fire        = psum_valid_i && psum_ready_o;
  assign push        = vld_q[L];
  assign out_valid_o = (cnt_q != '0);
  assign pop         = out_valid_o && out_ready_i;
  assign out_data_o  = fdat_q[rp_q];
  assign out_group_o = ftag_q[rp_q];
  assign sc_wx_o     = wx_q;
  assign sc_scale_o  = scale_q;
  assign sc_shift_o  = scsh_q;
  assign busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done        = (state_q == S_DONE);

  always_comb begin
    state_d  = state_q;
    issued_d = issued_q;
    total_d  = total_q;
    ngrp_d   = ngrp_q;
    grp_d    = grp_q;
    tbl_d    = tbl_q;
    shift_d  = shift_q;
    wx_d     = wx_q;
    scale_d  = scale_q;
    scsh_d   = scsh_q;
    fdat_d   = fdat_q;
    ftag_d   = ftag_q;
    wp_d     = wp_q;
    rp_d     = rp_q;
    cnt_d    = cnt_q;
    tag_d    = tag_q;

    case (state_q)
      S_IDLE: begin
        if (cfg_we)       tbl_d[cfg_addr] = cfg_wdata;
        if (cfg_shift_we) shift_d = cfg_shift;
        if (start) begin
          total_d  = total_vectors;
          ngrp_d   = (num_groups == '0) ? (AW+1)'(1) : num_groups;
          issued_d = '0;
          grp_d    = '0;
          state_d  = (total_vectors == 16'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN:   if (issued_q == total_q) state_d = S_DRAIN;
      S_DRAIN: if (inflight == '0 && cnt_q == '0) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    if (fire) begin
      wx_d     = psum_data_i;
      scale_d  = tbl_q[grp_q];
      scsh_d   = shift_q;
      issued_d = issued_q + 16'd1;
      grp_d    = (({1'b0, grp_q} + (AW+1)'(1)) == ngrp_q) ? '0 : grp_q + 1'b1;
    end

    vld_d[0] = fire;
    tag_d[0] = grp_q;
    for (int i = 1; i <= L; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end

    if (push) begin
      fdat_d[wp_q] = sc_y_i;
      ftag_d[wp_q] = tag_q[L];
      wp_d         = ptr_inc(wp_q);
    end
    if (pop) rp_d = ptr_inc(rp_q);
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!push && pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      issued_q <= '0;
      total_q  <= '0;
      ngrp_q   <= '0;
      grp_q    <= '0;
      shift_q  <= '0;
      wx_q     <= '0;
      scale_q  <= '0;
      scsh_q   <= '0;
      vld_q    <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < NUM_GROUPS_MAX; i++) tbl_q[i] <= '0;
      for (int i = 0; i <= L; i++) tag_q[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fdat_q[i] <= '0;
        ftag_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      issued_q <= issued_d;
      total_q  <= total_d;
      ngrp_q   <= ngrp_d;
      grp_q    <= grp_d;
      tbl_q    <= tbl_d;
      shift_q  <= shift_d;
      wx_q     <= wx_d;
      scale_q  <= scale_d;
      scsh_q   <= scsh_d;
      vld_q    <= vld_d;
      tag_q    <= tag_d;
      fdat_q   <= fdat_d;
      ftag_q   <= ftag_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: tb/tb_oscaler_ctrl.sv
// Scoreboard bench for oscaler_ctrl: directed passes with a behavioural 2-cycle scaler,
// expected outputs queued at stimulus time and checked by an output monitor.
module tb_oscaler_ctrl;
  localparam int NE = 4, EW = 20, OWD = 8, SCW = 16, SHW = 4, NG = 16, AW = 4;

  logic clk, rst;
  logic cfg_we, cfg_shift_we, start, busy, done;
  logic [AW-1:0] cfg_addr;
  logic [NE*SCW-1:0] cfg_wdata;
  logic [SHW-1:0] cfg_shift;
  logic [15:0] total_vectors;
  logic [AW:0] num_groups;
  logic psum_valid_i, psum_ready_o, out_valid_o, out_ready_i;
  logic [NE*EW-1:0] psum_data_i, sc_wx_o;
  logic [NE*SCW-1:0] sc_scale_o;
  logic [SHW-1:0] sc_shift_o;
  logic [NE*OWD-1:0] sc_y_i, out_data_o, s1, s2;
  logic [AW-1:0] out_group_o;

  oscaler_ctrl dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_shift_we(cfg_shift_we), .cfg_shift(cfg_shift), .start(start),
    .total_vectors(total_vectors), .num_groups(num_groups), .busy(busy), .done(done),
    .psum_valid_i(psum_valid_i), .psum_ready_o(psum_ready_o), .psum_data_i(psum_data_i),
    .sc_wx_o(sc_wx_o), .sc_scale_o(sc_scale_o), .sc_shift_o(sc_shift_o), .sc_y_i(sc_y_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_group_o(out_group_o)
  );

  typedef struct { logic [NE*OWD-1:0] data; logic [AW-1:0] grp; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  int n_chk = 0, n_fail = 0, n_out = 0, done_cnt = 0, cyc = 0;
  int first_fire_cyc = 0, first_valid_cyc = 0;
  bit arm_lat = 0, ready_seen = 0;
  logic [15:0] tb_tbl [NG];
  logic [SHW-1:0] tb_shift;

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] scl(input logic [19:0] wx, input logic [15:0] s,
                                     input logic [3:0] sh);
    logic [63:0] p;
    p = (64'(wx) * 64'(s)) >> (8 + int'(sh));
    return p[7:0];
  endfunction

  // Behavioural scaler: two register stages, never stalls.
  always @(posedge clk) begin
    for (int e = 0; e < NE; e++)
      s1[e*OWD +: OWD] <= scl(sc_wx_o[e*EW +: EW], sc_scale_o[e*SCW +: SCW], sc_shift_o);
    s2 <= s1;
  end
  assign sc_y_i = s2;

  function automatic logic [NE*EW-1:0] mkvec(input int v);
    logic [NE*EW-1:0] r;
    for (int e = 0; e < NE; e++) r[e*EW +: EW] = 20'(v*8 + e + 1);
    return r;
  endfunction

  function automatic logic [NE*OWD-1:0] exp_vec(input int v, input logic [15:0] s,
                                                input logic [3:0] sh);
    logic [NE*OWD-1:0] r;
    for (int e = 0; e < NE; e++) r[e*OWD +: OWD] = scl(20'(v*8 + e + 1), s, sh);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (psum_ready_o) ready_seen = 1;
    if (arm_lat && out_valid_o) begin
      first_valid_cyc = cyc;
      arm_lat = 0;
    end
    if (out_valid_o && out_ready_i) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got data %0h group %0d, expected none",
                 out_data_o, out_group_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (out_data_o !== mon_e.data || out_group_o !== mon_e.grp) begin
          n_fail++;
          $display("FAIL output_%0d: got data %0h group %0d, expected data %0h group %0d",
                   n_out, out_data_o, out_group_o, mon_e.data, mon_e.grp);
        end
      end
      n_out++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_tbl(input int a, input logic [15:0] s);
    cfg_we = 1; cfg_addr = AW'(a); cfg_wdata = {NE{s}};
    tick();
    cfg_we = 0;
    tb_tbl[a] = s;
  endtask

  task automatic do_start(input int tot, input int ng);
    start = 1; total_vectors = 16'(tot); num_groups = (AW+1)'(ng);
    tick();
    start = 0;
  endtask

  task automatic push_exp(input int tot, input int ng);
    int ge;
    exp_t e;
    ge = (ng == 0) ? 1 : ng;
    for (int v = 0; v < tot; v++) begin
      e.grp  = AW'(v % ge);
      e.data = exp_vec(v, tb_tbl[v % ge], tb_shift);
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input int v);
    bit ok;
    ok = 0;
    psum_valid_i = 1;
    psum_data_i = mkvec(v);
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (psum_ready_o) ok = 1;
    end
    if (!ok) chk("send_timeout", 128'(0), 128'(1));
    else begin
      tick();
      if (v == 0) first_fire_cyc = cyc;
    end
    psum_valid_i = 0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      if (done) ok = 1;
    end
    chk("done_seen", 128'(ok), 128'(1));
    tick();
  endtask

  // new_sh >= 0 writes the shift register in the same cycle as start.
  task automatic run_pass(input int tot, input int ng, input int new_sh);
    int d0;
    if (new_sh >= 0) begin
      tb_shift = SHW'(new_sh);
      cfg_shift_we = 1; cfg_shift = SHW'(new_sh);
    end
    push_exp(tot, ng);
    arm_lat = 1;
    d0 = done_cnt;
    do_start(tot, ng);
    cfg_shift_we = 0;
    for (int v = 0; v < tot; v++) send(v);
    wait_done();
    repeat (3) tick();
    chk("done_once", 128'(done_cnt - d0), 128'(1));
    chk("busy_low", 128'(busy), 128'(0));
    chk("sb_empty", 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, o0;
    rst = 1; cfg_we = 0; cfg_addr = '0; cfg_wdata = '0; cfg_shift_we = 0; cfg_shift = '0;
    start = 0; total_vectors = '0; num_groups = '0; psum_valid_i = 0; psum_data_i = '0;
    out_ready_i = 1;
    for (int i = 0; i < NG; i++) tb_tbl[i] = '0;
    tb_shift = '0;
    repeat (3) tick();
    rst = 0;
    tick();
    chk("reset_ctrl", 128'({busy, done, psum_ready_o, out_valid_o}), 128'(0));
    chk("reset_sc", 128'({sc_wx_o, sc_scale_o, sc_shift_o}), 128'(0));
    chk("reset_out", 128'({out_data_o, out_group_o}), 128'(0));

    // Single pass, no stall
    cfg_tbl(0, 16'h0100);
    cfg_tbl(1, 16'h0200);
    run_pass(4, 2, 0);
    chk("first_valid_latency", 128'(first_valid_cyc - first_fire_cyc), 128'(3));

    // Backpressure: exactly FIFO_DEPTH accepted while output stalls
    out_ready_i = 0;
    push_exp(6, 2);
    d0 = done_cnt;
    do_start(6, 2);
    for (int v = 0; v < 4; v++) send(v);
    o0 = n_out;
    repeat (6) tick();
    chk("bp_ready_low", 128'(psum_ready_o), 128'(0));
    chk("bp_out_valid", 128'(out_valid_o), 128'(1));
    chk("bp_no_pop", 128'(n_out - o0), 128'(0));
    out_ready_i = 1;
    send(4);
    send(5);
    wait_done();
    repeat (3) tick();
    chk("bp_done_once", 128'(done_cnt - d0), 128'(1));
    chk("bp_sb_empty", 128'(exp_q.size()), 128'(0));

    // total_vectors == 0
    ready_seen = 0;
    d0 = done_cnt;
    do_start(0, 2);
    chk("zero_done", 128'({done, busy}), 128'(2));
    tick();
    chk("zero_done_drop", 128'(done), 128'(0));
    chk("zero_done_once", 128'(done_cnt - d0), 128'(1));
    chk("zero_no_ready", 128'(ready_seen), 128'(0));

    // Config and start lockout while busy
    push_exp(4, 2);
    d0 = done_cnt;
    do_start(4, 2);
    send(0);
    cfg_we = 1; cfg_addr = '0; cfg_wdata = {NE{16'h0300}};
    cfg_shift_we = 1; cfg_shift = 4'd3;
    start = 1; total_vectors = 16'd2;
    send(1);
    cfg_we = 0; cfg_shift_we = 0; start = 0;
    send(2);
    send(3);
    wait_done();
    repeat (4) tick();
    chk("lock_done_once", 128'(done_cnt - d0), 128'(1));
    chk("lock_busy_low", 128'(busy), 128'(0));
    run_pass(4, 2, -1);

    // Group wrap, shift written together with start
    cfg_tbl(2, 16'h0300);
    run_pass(7, 3, 1);
    run_pass(3, 0, 0);

    // Reset with two vectors in flight
    exp_q.delete();
    do_start(4, 2);
    send(0);
    send(1);
    rst = 1;
    tick();
    chk("rst_ctrl", 128'({busy, done, psum_ready_o, out_valid_o}), 128'(0));
    chk("rst_sc", 128'({sc_wx_o, sc_scale_o, sc_shift_o}), 128'(0));
    chk("rst_out", 128'({out_data_o, out_group_o}), 128'(0));
    rst = 0;
    for (int i = 0; i < NG; i++) tb_tbl[i] = '0;
    tb_shift = '0;
    o0 = n_out;
    repeat (6) tick();
    chk("rst_no_stale", 128'({out_valid_o, 8'(n_out - o0)}), 128'(0));
    cfg_tbl(0, 16'h0100);
    cfg_tbl(1, 16'h0180);
    run_pass(3, 2, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
